// File: rtl/led_sequencer_pkg.sv
// Shared types for the LED sequencer: display pattern select, bounce direction
// and the position-counter width helper.
package led_seq_pkg;

    typedef enum logic [1:0] {
        BOUNCE = 2'd0,
        WRAP   = 2'd1,
        FILL   = 2'd2,
        BLINK  = 2'd3
    } led_mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // FILL needs pos to reach N_LEDS, so the counter must hold 0..2*N_LEDS-1.
    function automatic int POS_W(input int n_leds);
        return $clog2(2 * n_leds);
    endfunction

endpackage

// File: rtl/led_sequencer_if.sv
// Control and display signals between the board switches/buttons and the sequencer.
interface led_sequencer_if #(
    parameter int N_LEDS  = 8,
    parameter int DELAY_W = 4
);
    logic               pause;
    logic               step;
    logic [1:0]         mode;
    logic [DELAY_W-1:0] delay;
    logic [N_LEDS-1:0]  led;
    logic               running;
    logic               tick;

    modport master (
        output pause, step, mode, delay,
        input  led, running, tick
    );

    modport slave (
        input  pause, step, mode, delay,
        output led, running, tick
    );
endinterface

// File: rtl/led_sequencer_decode.sv
// Combinational pattern decode: turns the registered mode and position into LED levels.
module led_pattern_decode
    import led_seq_pkg::*;
#(
    parameter int N_LEDS = 8,
    parameter int PW     = 4
) (
    input  led_mode_t         mode,
    input  logic [PW-1:0]     pos,
    output logic [N_LEDS-1:0] led
);

    always_comb begin
        led = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            case (mode)
                BOUNCE, WRAP: led[i] = (pos == PW'(i));
                FILL:         led[i] = (PW'(i) < pos);
                BLINK:        led[i] = (pos == '0);
                default:      led[i] = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: programmable-rate position stepping with run/pause,
// single-step and runtime mode switching; the pattern decode is a sub-module.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int N_LEDS     = 8,
    parameter int DELAY_W    = 4,
    parameter int PRESCALE_W = 20
) (
    input  logic           clk,
    input  logic           reset,
    led_sequencer_if.slave bus
);

    localparam int CNT_W = DELAY_W + PRESCALE_W;
    localparam int PW    = POS_W(N_LEDS);
    localparam logic [PW-1:0] LAST = PW'(N_LEDS - 1);
    localparam logic [PW-1:0] FULL = PW'(N_LEDS);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] reload;
    logic [PW-1:0]    pos;
    logic [PW-1:0]    pos_next;
    dir_t             dir;
    dir_t             dir_next;
    logic             running_q;
    logic             tick_q;
    logic             pause_q;
    led_mode_t        mode_q;
    led_mode_t        mode_in;

    assign reload  = {bus.delay, {PRESCALE_W{1'b0}}};
    assign mode_in = led_mode_t'(bus.mode);

    // Next position for one advance step in the currently latched mode.
    always_comb begin
        pos_next = pos;
        dir_next = dir;
        case (mode_q)
            BOUNCE: begin
                if (dir == DIR_UP) begin
                    if (pos == LAST) begin
                        pos_next = pos - PW'(1);
                        dir_next = DIR_DOWN;
                    end else begin
                        pos_next = pos + PW'(1);
                    end
                end else begin
                    if (pos == '0) begin
                        pos_next = pos + PW'(1);
                        dir_next = DIR_UP;
                    end else begin
                        pos_next = pos - PW'(1);
                    end
                end
            end
            WRAP:    pos_next = (pos == LAST) ? '0 : pos + PW'(1);
            FILL:    pos_next = (pos == FULL) ? '0 : pos + PW'(1);
            BLINK:   pos_next = (pos == '0) ? PW'(1) : '0;
            default: pos_next = '0;
        endcase
    end

    // Mode change beats a pause edge, which beats stepping and timed advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            pos       <= '0;
            dir       <= DIR_UP;
            running_q <= 1'b1;
            tick_q    <= 1'b0;
            pause_q   <= 1'b1;
            mode_q    <= mode_in;
        end else begin
            pause_q <= bus.pause;
            tick_q  <= 1'b0;
            if (mode_in != mode_q) begin
                mode_q <= mode_in;
                pos    <= '0;
                dir    <= DIR_UP;
                count  <= reload;
            end else if (bus.pause && !pause_q) begin
                running_q <= !running_q;
            end else if ((bus.step && !running_q) || (running_q && count == '0)) begin
                pos    <= pos_next;
                dir    <= dir_next;
                count  <= reload;
                tick_q <= 1'b1;
            end else if (running_q) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign bus.running = running_q;
    assign bus.tick    = tick_q;

    led_pattern_decode #(
        .N_LEDS (N_LEDS),
        .PW     (PW)
    ) u_decode (
        .mode (mode_q),
        .pos  (pos),
        .led  (bus.led)
    );

endmodule

// File: tb/tb_led_sequencer.sv
// Randomised scoreboard bench for led_sequencer with a phase-index reference model.
module tb_led_sequencer;
    import led_seq_pkg::*;

    localparam int N  = 4;
    localparam int DW = 4;
    localparam int PS = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    led_sequencer_if #(.N_LEDS(N), .DELAY_W(DW)) bus ();

    led_sequencer #(
        .N_LEDS     (N),
        .DELAY_W    (DW),
        .PRESCALE_W (PS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           cyc;
        logic [N-1:0] led;
        logic         run;
    } tick_exp_t;

    typedef struct {
        int           cyc;
        string        name;
        logic [N-1:0] led;
        logic         run;
        logic         tick;
    } snap_exp_t;

    tick_exp_t tick_q[$];
    snap_exp_t snap_q[$];

    int tests  = 0;
    int fails  = 0;
    bit mon_en = 1'b0;
    bit done   = 1'b0;

    // Reference model: phase index within each pattern's period, not a position/direction pair.
    int m_mode, m_idx, m_cnt;
    bit m_run, m_pq, m_tick;

    function automatic int period(input int md);
        case (md)
            0:       return 2 * N - 2;
            1:       return N;
            2:       return N + 1;
            default: return 2;
        endcase
    endfunction

    function automatic logic [N-1:0] pattern(input int md, input int idx);
        case (md)
            0:       return (idx < N) ? N'(1 << idx) : N'(1 << (2 * N - 2 - idx));
            1:       return N'(1 << idx);
            2:       return N'((1 << idx) - 1);
            default: return (idx == 0) ? {N{1'b1}} : {N{1'b0}};
        endcase
    endfunction

    task automatic model_step(input bit r, input bit p, input bit s, input int md, input int dl);
        bit edge_seen;
        if (r) begin
            m_cnt = 0; m_idx = 0; m_run = 1; m_pq = 1; m_mode = md; m_tick = 0;
        end else begin
            m_tick    = 0;
            edge_seen = p && !m_pq;
            m_pq      = p;
            if (md != m_mode) begin
                m_mode = md;
                m_idx  = 0;
                m_cnt  = dl * (1 << PS);
            end else if (edge_seen) begin
                m_run = !m_run;
            end else if ((s && !m_run) || (m_run && m_cnt == 0)) begin
                m_idx  = (m_idx + 1) % period(m_mode);
                m_cnt  = dl * (1 << PS);
                m_tick = 1;
            end else if (m_run) begin
                m_cnt = m_cnt - 1;
            end
        end
    endtask

    task automatic applyStimulus(input bit r, input bit p, input bit s, input int md, input int dl);
        tick_exp_t e;
        @(negedge clk);
        reset     = r;
        bus.pause = p;
        bus.step  = s;
        bus.mode  = 2'(md);
        bus.delay = DW'(dl);
        model_step(r, p, s, md, dl);
        if (m_tick) begin
            e.cyc = cyc + 1;
            e.led = pattern(m_mode, m_idx);
            e.run = m_run;
            tick_q.push_back(e);
        end
    endtask

    task automatic idle(input int n, input bit p, input int md, input int dl);
        for (int i = 0; i < n; i++) applyStimulus(0, p, 0, md, dl);
    endtask

    task automatic checkOutput(input string name);
        snap_exp_t s;
        s.cyc  = cyc + 1;
        s.name = name;
        s.led  = pattern(m_mode, m_idx);
        s.run  = m_run;
        s.tick = m_tick;
        snap_q.push_back(s);
    endtask

    task automatic checkLiteral(input string name, input logic [N-1:0] led, input logic run, input logic tick);
        snap_exp_t s;
        s.cyc  = cyc + 1;
        s.name = name;
        s.led  = led;
        s.run  = run;
        s.tick = tick;
        snap_q.push_back(s);
    endtask

    // Monitor: sole owner of the counters; pops expectations as the DUT presents ticks.
    always @(negedge clk) begin
        tick_exp_t e;
        snap_exp_t s;
        if (mon_en) begin
            while (tick_q.size() > 0 && tick_q[0].cyc < cyc) begin
                tests++; fails++;
                $display("[TB] FAIL tick_missing cycle %0d: tick got 0, required 1", tick_q[0].cyc);
                void'(tick_q.pop_front());
            end
            if (bus.tick === 1'b1) begin
                tests++;
                if (tick_q.size() == 0 || tick_q[0].cyc != cyc) begin
                    fails++;
                    $display("[TB] FAIL tick_spurious cycle %0d: tick got 1, required 0", cyc);
                end else begin
                    e = tick_q.pop_front();
                    if (bus.led !== e.led || bus.running !== e.run) begin
                        fails++;
                        $display("[TB] FAIL tick_value cycle %0d: led got %h required %h, running got %b required %b",
                                 cyc, bus.led, e.led, bus.running, e.run);
                    end
                end
            end else if (tick_q.size() > 0 && tick_q[0].cyc == cyc) begin
                tests++; fails++;
                $display("[TB] FAIL tick_missing cycle %0d: tick got %b, required 1", cyc, bus.tick);
                void'(tick_q.pop_front());
            end
            while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
                s = snap_q.pop_front();
                if (s.cyc == cyc) begin
                    tests++;
                    if (bus.led !== s.led || bus.running !== s.run || bus.tick !== s.tick) begin
                        fails++;
                        $display("[TB] FAIL %s cycle %0d: led/running/tick got %h/%b/%b required %h/%b/%b",
                                 s.name, cyc, bus.led, bus.running, bus.tick, s.led, s.run, s.tick);
                    end
                end
            end
            if (done) begin
                tests++;
                if (tick_q.size() != 0) begin
                    fails++;
                    $display("[TB] FAIL tick_leftover: pending got %0d, required 0", tick_q.size());
                end
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $finish;
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: finished got 0, required 1");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bit p, s, r;
        int md, dl;
        bus.pause = 1'b0;
        bus.step  = 1'b0;
        bus.mode  = 2'd0;
        bus.delay = DW'(1);

        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 1);
        mon_en = 1'b1;
        checkLiteral("reset_state", 4'h1, 1'b1, 1'b0);

        // Bounce at delay 1, then fast wrap, fill and blink.
        idle(45, 0, 0, 1);
        checkOutput("bounce_run");
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("wrap_change");
        idle(12, 0, 1, 0);
        applyStimulus(0, 0, 0, 2, 0);
        checkLiteral("fill_change", 4'h0, 1'b1, 1'b0);
        idle(12, 0, 2, 0);
        applyStimulus(0, 0, 0, 3, 0);
        checkLiteral("blink_change", 4'hF, 1'b1, 1'b0);
        idle(8, 0, 3, 0);

        // Pause, hold, single steps, resume, step while running.
        applyStimulus(0, 0, 0, 0, 1);
        idle(7, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("pause_stop");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 1, 0, 0, 1);
            checkOutput("pause_frozen");
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 1, 0, 1);
            checkOutput("step_advance");
            idle(2, 1, 0, 1);
        end
        idle(2, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("pause_resume");
        applyStimulus(0, 1, 1, 0, 1);
        checkOutput("step_while_running");
        idle(6, 1, 0, 1);

        // Pause edge with count at zero, then mode change against a pause edge.
        idle(3, 0, 1, 0);
        applyStimulus(0, 1, 0, 1, 0);
        checkOutput("pause_at_zero");
        idle(2, 0, 1, 0);
        applyStimulus(0, 1, 0, 2, 0);
        checkOutput("mode_beats_pause");
        idle(2, 0, 2, 0);
        applyStimulus(0, 1, 0, 2, 0);
        checkOutput("resume_after_lost_edge");
        idle(4, 1, 2, 0);

        // Reset mid-interval with pause held high.
        idle(6, 0, 0, 3);
        applyStimulus(0, 1, 0, 0, 3);
        applyStimulus(1, 1, 0, 0, 3);
        applyStimulus(1, 1, 0, 0, 3);
        checkLiteral("reset_pause_held", 4'h1, 1'b1, 1'b0);
        applyStimulus(0, 1, 0, 0, 3);
        checkLiteral("first_tick_after_reset", 4'h2, 1'b1, 1'b1);
        idle(10, 1, 0, 3);

        // Randomised phase.
        p  = 1'b1;
        md = 0;
        dl = 1;
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 24) == 0) p = !p;
            s = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 39) == 0) md = int'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) dl = int'($urandom_range(0, 2));
            applyStimulus(r, p, s, md, dl);
            if (i % 16 == 0) checkOutput("random_state");
        end

        applyStimulus(1, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 1);
        @(negedge clk);
        done = 1'b1;
    end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Parametrised LED pattern sequencer for the board-level status and debug LED bank. It steps a position counter at a programmable rate and decodes it into one of four display patterns (bounce, rotate, fill, blink) across `N_LEDS` outputs. It adds edge-detected run/pause, single-step while paused, and mode switching at runtime. It sits directly between the top-level switch/button inputs and the LED pins.

## Interface
- `N_LEDS`, 8, number of LED outputs; legal values are 2 to 32.
- `DELAY_W`, 4, width of the `delay` input.
- `PRESCALE_W`, 20, number of fixed zero LSBs appended to `delay` to form the reload value.
- `clk`  in  1  system clock.
- `reset`  in  1  reset. Synchronous, active-high. Clock is `clk`.
- `pause`  in  1  level input. Each rising edge toggles the run state.
- `step`  in  1  one-cycle pulse. Advances one position while paused; ignored while running.
- `mode`  in  2  pattern select: 0 BOUNCE, 1 WRAP, 2 FILL, 3 BLINK.
- `delay`  in  DELAY_W  advance interval, in units of 2^PRESCALE_W cycles.
- `led`  out  N_LEDS  decoded pattern.
- `running`  out  1  current run state.
- `tick`  out  1  one-cycle pulse, high in the cycle the position advances.

## Operation
- State registers:
  - `count`, width DELAY_W+PRESCALE_W.
  - `pos`, width clog2(2*N_LEDS).
  - `dir`, up/down.
  - `running`.
  - `pause_q`.
  - `mode_q`.
- Reset values:
  - `count` = 0, `pos` = 0, `dir` = up.
  - `running` = 1, `tick` = 0.
  - `pause_q` = 1, so a `pause` held high through reset causes no toggle.
  - `mode_q` = `mode`.
- Per-cycle priority, highest first:
  1. reset.
  2. Mode change (`mode != mode_q`): `pos` = 0, `dir` = up, `count` = reload, `mode_q` = `mode`, no tick.
  3. Pause rising edge (`pause && !pause_q`): toggle `running`; `count` and `pos` hold; no tick.
  4. `step && !running`: advance, `count` = reload, tick.
  5. `running && count == 0`: advance, `count` = reload, tick.
  6. `running && count != 0`: `count` decrements by 1.
- `pause_q` <= `pause` every cycle, including cycles where a higher-priority event fires.
- Reload value is `{delay, PRESCALE_W'b0}`. `delay` is sampled only at reload.
- Advance rules per mode:
  - BOUNCE: `pos` ping-pongs 0..N-1..0, reversing `dir` at 0 and at N-1. Period is 2N-2 advances. `led` = one-hot at bit `pos`.
  - WRAP: `pos` goes 0..N-1, then back to 0. `led` = one-hot at bit `pos`.
  - FILL: `pos` goes 0..N, then back to 0. `led` = low `pos` bits set, so `pos` = 0 is all off and `pos` = N is all on.
  - BLINK: `pos` toggles between 0 and 1. `pos` = 0 is all on; `pos` = 1 is all off.
- `led` is a combinational decode of `mode_q`, `pos`.
  - Reset `led` depends on `mode_q`: BOUNCE/WRAP give `1`, FILL gives `0`, BLINK gives all ones.
- No advance while paused other than via `step`. `step` while running has no effect.

## Timing
- First tick arrives 1 cycle after reset release, because `count` resets to 0.
- Steady-state tick spacing is delay*2^PRESCALE_W + 1 cycles. `delay` = 0 gives a tick every cycle.
- `tick` and the new `led` value appear in the same cycle, one clock after the qualifying condition.
- A pause edge coincident with `count == 0` toggles `running` only. The advance happens on the next cycle if still running.
- A mode change wins over a coincident pause edge. The edge is lost; `pause_q` still updates.
- Reset mid-interval returns all state to reset values on the next edge.

## Structure
- Package `led_seq_pkg` holds:
  - typedef enum `led_mode_t` {BOUNCE, WRAP, FILL, BLINK}.
  - a clog2-based `POS_W` function.
- One sub-module, `led_pattern_decode`: purely combinational, maps (`mode_q`, `pos`) to `led`, parametrised by `N_LEDS`.
- All sequential logic stays in `led_sequencer`.

## Test plan
Bench configuration: N_LEDS=4, DELAY_W=4, PRESCALE_W=2.
- Reset release, mode=0, delay=1: ticks every 5 cycles; `led` sequence is 1,2,4,8,4,2,1,2.
- mode=1, delay=0: `tick` is high every cycle; `led` sequence is 1,2,4,8,1.
- mode=2: `led` sequence is 0,1,3,7,F,0. Then mode=3: `led` shows F in the cycle after the change, then alternates 0/F.
- Pause rising edge: `running` drops and `led` freezes. Holding `pause` high causes no further toggle. Three `step` pulses give 3 ticks and advance `led` 3 positions. A `step` while running gives no extra tick.
- Pause edge coincident with `count` == 0: no tick that cycle, `running` = 0. Mode change coincident with a pause edge: `running` unchanged, `pos` = 0.
- Reset asserted mid-interval with `pause` held high: after release `running` = 1 (no spurious toggle), `led` = 1 in mode 0, first tick 1 cycle later.
